// File: rtl/display_pkg.sv
// Shared types and constants for the 8-digit seven-segment scanner.
package display_pkg;

   localparam int unsigned NUM_DIGITS = 8;

   typedef logic [3:0] digit_idx_t;
   typedef logic [3:0] nibble_t;

   localparam digit_idx_t DIG_A_HI = 4'd0;
   localparam digit_idx_t DIG_A_LO = 4'd1;
   localparam digit_idx_t DIG_B_HI = 4'd4;
   localparam digit_idx_t DIG_B_LO = 4'd5;
   localparam digit_idx_t DIG_R_HI = 4'd6;
   localparam digit_idx_t DIG_R_LO = 4'd7;
   localparam digit_idx_t DIG_LAST = digit_idx_t'(NUM_DIGITS - 1);

   // One complete set of display data, as held in the shadow and active registers
   typedef struct packed {
      logic [7:0] op_a;
      logic [7:0] op_b;
      logic [7:0] result;
      logic       show_result;
   } disp_data_t;

   // Hex nibble shown on a given digit; digits 2 and 3 are blank (zero)
   function automatic nibble_t digit_nibble_of(input digit_idx_t idx, input disp_data_t d);
      nibble_t nib;
      nib = 4'h0;
      case (idx)
         DIG_A_HI: nib = d.op_a[7:4];
         DIG_A_LO: nib = d.op_a[3:0];
         DIG_B_HI: nib = d.op_b[7:4];
         DIG_B_LO: nib = d.op_b[3:0];
         DIG_R_HI: nib = d.result[7:4];
         DIG_R_LO: nib = d.result[3:0];
         default:  nib = 4'h0;
      endcase
      return nib;
   endfunction

endpackage

// File: rtl/refresh_prescaler.sv
// Digit-slot prescaler: tick_o is high for one cycle every REFRESH_DIV cycles;
// tick_next_c flags the cycle just before it.
module refresh_prescaler #(
   parameter int unsigned REFRESH_DIV = 100000
) (
   input  logic clk,
   input  logic reset,
   output logic tick_o,
   output logic tick_next_c
);

   localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(REFRESH_DIV - 2);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;

   // tick is registered one count early so it coincides with the terminal count
   always_comb begin
      cnt_d       = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      tick_next_c = (cnt_q == CNT_PRE);
      tick_d      = tick_next_c;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick_o = tick_q;

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed 8-digit display scanner with frame-aligned double buffering.
// Optional DISPLAY_SKIP_EN: scan only the digits lit for the committed position.
module display_scanner
   import display_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 100000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] op_a,
   input  logic [7:0] op_b,
   input  logic [7:0] result,
   input  logic       show_result,
   input  logic       update,
   output logic [3:0] digit_idx,
   output logic [3:0] digit_nibble,
   output logic       position,
   output logic       pending,
   output logic       frame_done
);

   logic       tick;
   logic       tick_next;
   logic       boundary;
   digit_idx_t last_digit;
   disp_data_t in_data;

   disp_data_t shadow_q, shadow_d;
   disp_data_t active_q, active_d;
   logic       pending_q, pending_d;
   digit_idx_t digit_q, digit_d;
   nibble_t    nibble_q, nibble_d;
   logic       frame_done_q, frame_done_d;

   refresh_prescaler #(
      .REFRESH_DIV (REFRESH_DIV)
   ) u_prescaler (
      .clk         (clk),
      .reset       (reset),
      .tick_o      (tick),
      .tick_next_c (tick_next)
   );

   always_comb begin
      in_data.op_a        = op_a;
      in_data.op_b        = op_b;
      in_data.result      = result;
      in_data.show_result = show_result;
`ifdef DISPLAY_SKIP_EN
      last_digit = active_q.show_result ? DIG_R_LO : DIG_B_LO;
`else
      last_digit = DIG_LAST;
`endif
      boundary = tick && (digit_q == last_digit);
   end

   // Shadow capture, frame-boundary commit and digit sequencing
   always_comb begin
      shadow_d     = shadow_q;
      active_d     = active_q;
      pending_d    = pending_q;
      digit_d      = digit_q;
      frame_done_d = tick_next && (digit_q == last_digit);

      if (update) begin
         shadow_d  = in_data;
         pending_d = 1'b1;
      end

      if (boundary) begin
         if (update) begin
            active_d = in_data;
         end else if (pending_q) begin
            active_d = shadow_q;
         end
         pending_d = 1'b0;
      end

      if (tick) begin
`ifdef DISPLAY_SKIP_EN
         if (boundary) begin
            digit_d = active_d.show_result ? DIG_R_HI : DIG_A_HI;
         end else begin
            case (digit_q)
               DIG_A_HI: digit_d = DIG_A_LO;
               DIG_A_LO: digit_d = DIG_B_HI;
               DIG_B_HI: digit_d = DIG_B_LO;
               DIG_R_HI: digit_d = DIG_R_LO;
               default:  digit_d = DIG_A_HI;
            endcase
         end
`else
         digit_d = boundary ? DIG_A_HI : digit_q + digit_idx_t'(1);
`endif
      end

      // Nibble follows the next digit and next active data so both change together
      nibble_d = digit_nibble_of(digit_d, active_d);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shadow_q     <= '0;
         active_q     <= '0;
         pending_q    <= 1'b0;
         digit_q      <= DIG_A_HI;
         nibble_q     <= '0;
         frame_done_q <= 1'b0;
      end else begin
         shadow_q     <= shadow_d;
         active_q     <= active_d;
         pending_q    <= pending_d;
         digit_q      <= digit_d;
         nibble_q     <= nibble_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign digit_idx    = digit_q;
   assign digit_nibble = nibble_q;
   assign position     = active_q.show_result;
   assign pending      = pending_q;
   assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_display_scanner.sv
// Randomized bench for display_scanner against a frame/slot-level reference model.
module tb_display_scanner;

   localparam int unsigned DIV = 4;
   localparam int unsigned N_CYCLES = 3000;

   logic       clk;
   logic       reset;
   logic [7:0] op_a, op_b, result;
   logic       show_result, update;
   logic [3:0] digit_idx, digit_nibble;
   logic       position, pending, frame_done;

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;

   // Reference model: slot position within the frame and cycle within the slot
   int unsigned m_cyc, m_slot;
   logic [7:0]  m_a, m_b, m_r;
   logic        m_show;
   logic [7:0]  s_a, s_b, s_r;
   logic        s_show;
   logic        m_pend;
   int unsigned fd_cnt;

   display_scanner #(
      .REFRESH_DIV (DIV)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .op_a         (op_a),
      .op_b         (op_b),
      .result       (result),
      .show_result  (show_result),
      .update       (update),
      .digit_idx    (digit_idx),
      .digit_nibble (digit_nibble),
      .position     (position),
      .pending      (pending),
      .frame_done   (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int unsigned seq_len(input logic show);
`ifdef DISPLAY_SKIP_EN
      return show ? 2 : 4;
`else
      return 8;
`endif
   endfunction

   function automatic int unsigned seq_digit(input logic show, input int unsigned slot);
`ifdef DISPLAY_SKIP_EN
      if (show) return 6 + slot;
      return (slot < 2) ? slot : slot + 2;
`else
      return slot;
`endif
   endfunction

   function automatic logic [3:0] exp_nibble(input int unsigned d);
      logic [3:0] nib [8];
      nib[0] = m_a[7:4]; nib[1] = m_a[3:0];
      nib[2] = 4'h0;     nib[3] = 4'h0;
      nib[4] = m_b[7:4]; nib[5] = m_b[3:0];
      nib[6] = m_r[7:4]; nib[7] = m_r[3:0];
      return nib[d];
   endfunction

   function automatic logic at_boundary();
      return (m_cyc == DIV - 1) && (m_slot == seq_len(m_show) - 1);
   endfunction

   task automatic model_reset();
      m_cyc = 0; m_slot = 0;
      m_a = 0; m_b = 0; m_r = 0; m_show = 0;
      s_a = 0; s_b = 0; s_r = 0; s_show = 0;
      m_pend = 0;
   endtask

   // Advance the model across one clock edge using the inputs currently driven
   task automatic model_step();
      logic bnd;
      if (reset) begin
         model_reset();
         return;
      end
      bnd = at_boundary();
      if (update && !bnd) begin
         s_a = op_a; s_b = op_b; s_r = result; s_show = show_result;
         m_pend = 1;
      end
      if (bnd) begin
         if (update) begin
            m_a = op_a; m_b = op_b; m_r = result; m_show = show_result;
         end else if (m_pend) begin
            m_a = s_a; m_b = s_b; m_r = s_r; m_show = s_show;
         end
         m_pend = 0;
         m_slot = 0;
      end else if (m_cyc == DIV - 1) begin
         m_slot++;
      end
      m_cyc = (m_cyc == DIV - 1) ? 0 : m_cyc + 1;
   endtask

   task automatic check_outputs();
      int unsigned d;
      d = seq_digit(m_show, m_slot);
      check_eq("digit_idx",    32'(digit_idx),    32'(d));
      check_eq("digit_nibble", 32'(digit_nibble), 32'(exp_nibble(d)));
      check_eq("position",     32'(position),     32'(m_show));
      check_eq("pending",      32'(pending),      32'(m_pend));
      check_eq("frame_done",   32'(frame_done),   32'(at_boundary()));
   endtask

   initial begin
      reset = 1'b1; update = 1'b0;
      op_a = '0; op_b = '0; result = '0; show_result = 1'b0;
      fd_cnt = 0;
      repeat (2) @(negedge clk);
      model_reset();
      check_eq("rst_digit_idx",    32'(digit_idx),    32'd0);
      check_eq("rst_digit_nibble", 32'(digit_nibble), 32'd0);
      check_eq("rst_position",     32'(position),     32'd0);
      check_eq("rst_pending",      32'(pending),      32'd0);
      check_eq("rst_frame_done",   32'(frame_done),   32'd0);

      for (int i = 0; i < N_CYCLES; i++) begin
         reset  = 1'b0;
         update = 1'b0;
         if (i >= 32) begin
            op_a        = 8'($urandom);
            op_b        = 8'($urandom);
            result      = 8'($urandom);
            show_result = 1'($urandom);
            if (at_boundary())
               update = ($urandom_range(0, 1) == 0);
            else
               update = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 299) == 0) begin
               reset  = 1'b1;
               update = 1'b0;
            end
         end
         model_step();
         @(negedge clk);
         check_outputs();
         if (i < 32 && frame_done === 1'b1) fd_cnt++;
         if (i == 31) begin
`ifdef DISPLAY_SKIP_EN
            check_eq("idle_frame_pulses", 32'(fd_cnt), 32'd2);
`else
            check_eq("idle_frame_pulses", 32'(fd_cnt), 32'd1);
`endif
         end
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/display_scanner.md
# display_scanner

Time-multiplexing controller for the Nexys 4 DDR 8-digit seven-segment display, driving the existing segment/anode decoder stage. Holds operand A, operand B and result bytes, refreshes one digit per refresh tick, and emits the digit index, hex nibble and operator/result position flag that the decoder consumes. Inputs are double-buffered and committed only at frame boundaries, so a frame never mixes old and new values.

## Interface
- REFRESH_DIV, 100000: clk cycles per digit slot; 1 kHz digit rate at 100 MHz; minimum 2.
- clk  input  1  system clock.
- reset  input  1  reset, synchronous, active-high; clock clk.
- op_a  input  8  operand A; digits 0 (high nibble) and 1 (low nibble).
- op_b  input  8  operand B; digits 4 (high) and 5 (low).
- result  input  8  result; digits 6 (high) and 7 (low).
- show_result  input  1  0 = operator view, 1 = result view.
- update  input  1  single-cycle strobe; captures op_a/op_b/result/show_result into the shadow registers.
- digit_idx  output  4  digit currently driven, 0..7; feeds decoder display-select.
- digit_nibble  output  4  hex value for that digit; feeds decoder value input.
- position  output  1  committed show_result; feeds decoder position input.
- pending  output  1  shadow data captured but not yet committed.
- frame_done  output  1  one-cycle pulse on the last digit slot's expiry.

## Operation
- Prescaler counts 0..REFRESH_DIV-1; tick asserted on terminal count, prescaler returns to 0.
- On tick, digit counter advances to next digit in sequence; wrap from last digit to first is a frame boundary.
- Nibble map: 0 → active_a[7:4], 1 → active_a[3:0], 4 → active_b[7:4], 5 → active_b[3:0], 6 → active_r[7:4], 7 → active_r[3:0]; digits 2 and 3 → 4'h0.
- update high: shadow ← inputs, pending ← 1. Repeated updates before commit overwrite the shadow; last one wins.
- Frame boundary with pending = 1: active ← shadow, position ← shadow show_result, pending ← 0.
- update on the boundary cycle: inputs bypass the shadow and commit directly; pending stays 0.
- frame_done asserted in the cycle in which the boundary tick occurs.

## Timing
- Reset values: digit_idx 0, digit_nibble 4'h0, position 0, pending 0, frame_done 0, prescaler 0, active and shadow registers 0.
- digit_idx, digit_nibble and position are registered. They change in the cycle after the tick and hold for exactly REFRESH_DIV cycles.
- digit_nibble is always consistent with the digit_idx and active data in the same cycle.
- First tick occurs REFRESH_DIV cycles after reset deassertion.
- A committed update is visible on the first digit of the next frame. Worst-case latency is one frame plus one cycle.
- pending rises in the cycle after update and falls in the cycle after the commit.
- Reset mid-frame discards shadow data and pending, and restarts at digit 0 with the prescaler at 0.

## Configuration
- DISPLAY_SKIP_EN defined: sequence visits only the digits lit for the committed position. This is 0,1,4,5 for position 0 and 6,7 for position 1, which raises the duty cycle. The frame boundary is the wrap from 5 to 0 or from 7 to 6. If position changes at commit, the next digit is the first digit of the new sequence.
- DISPLAY_SKIP_EN undefined: full 0..7 sequence, boundary on the wrap from 7 to 0. Unlit digits still occupy their slots.

## Structure
- Shared package display_pkg holds:
  - NUM_DIGITS = 8.
  - typedef digit_idx_t and nibble_t (logic [3:0]).
  - Named digit constants DIG_A_HI=0, DIG_A_LO=1, DIG_B_HI=4, DIG_B_LO=5, DIG_R_HI=6, DIG_R_LO=7.
- Sub-module refresh_prescaler is parameterised by REFRESH_DIV and outputs the single-cycle tick.
- The digit sequencer, shadow/active registers and nibble mux live in display_scanner.

## Test plan
All scenarios use REFRESH_DIV = 4.
- Reset then idle for 32 cycles → digit_idx steps 0..7, each held 4 cycles; digit_nibble 0; frame_done pulses once at cycle 32.
- update with op_a=8'h3C, op_b=8'hA5, show_result=0 mid-frame → pending=1 until the boundary. Next frame shows digit 0→3, 1→C, 4→A, 5→5, 2/3→0; pending returns to 0.
- update with result=8'h7F, show_result=1 → after commit position=1, digit 6→7, digit 7→F.
- Two updates in one frame (op_a=8'h11, then op_a=8'h22) → only 2,2 is ever displayed for digits 0/1.
- update on the exact boundary cycle with op_b=8'hE9 → digits 4/5 show E/9 in that same new frame; pending never asserts.
- DISPLAY_SKIP_EN defined, position=0 → sequence 0,1,4,5 with a 16-cycle frame. Committing show_result=1 switches to sequence 6,7 with an 8-cycle frame. Asserting reset mid-frame returns digit_idx to 0 with pending=0.
